// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared definitions for the write-back stage.
//   - WB_SEL_* : write-back source select encodings
//   - bus widths towards the GPR/CSR register file
//   - FSM state encoding
//   - packed layout of wu_to_gu_bus (MSB first)
package ysyx_25020037_wbu_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_CSR  = 2'd2;
    localparam logic [1:0] WB_SEL_PC4  = 2'd3;

    localparam int WU_TO_GU_BUS_WD = 74;
    localparam int EU_TO_GU_BUS_WD = 3;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } wbu_state_e;

    // Field order defines the bit layout: rd lands in [73:70], gpr_wdata in [31:0].
    typedef struct packed {
        logic [3:0]  rd;
        logic        ecall_en;
        logic        mret_en;
        logic [2:0]  csr_wen;        // {mtvec_wen, mepc_wen, mstatus_wen}
        logic [31:0] csr_wcsr_data;
        logic        gpr_wen;
        logic [31:0] gpr_wdata;
    } wu_to_gu_bus_t;

endpackage

// File: rtl/ysyx_25020037_wb_mux.sv
// Write-back value select and GPR write gating.
//   i_wb_sel      : source select (ALU / load / CSR read / pc+4)
//   i_pc, i_alu_res, i_load_data, i_csr_rdata : candidate sources
//   i_rd, i_gpr_wen, i_trap : destination and raw write enable, trap flag
//   o_gpr_wdata   : selected value
//   o_gpr_wen     : write enable, suppressed for rd==0 and for traps
module ysyx_25020037_wb_mux
    import ysyx_25020037_wbu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 4
) (
    input  logic [1:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic [XLEN-1:0] i_load_data,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic [RD_W-1:0] i_rd,
    input  logic            i_gpr_wen,
    input  logic            i_trap,
    output logic [XLEN-1:0] o_gpr_wdata,
    output logic            o_gpr_wen
);

    always_comb begin
        o_gpr_wdata = i_alu_res;
        case (i_wb_sel)
            WB_SEL_ALU:  o_gpr_wdata = i_alu_res;
            WB_SEL_LOAD: o_gpr_wdata = i_load_data;
            WB_SEL_CSR:  o_gpr_wdata = i_csr_rdata;
            WB_SEL_PC4:  o_gpr_wdata = i_pc + XLEN'(4);   // wraps naturally
            default:     o_gpr_wdata = i_alu_res;
        endcase
    end

    assign o_gpr_wen = i_gpr_wen & (i_rd != '0) & ~i_trap;

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back / commit stage.
//   lsu_valid / wbu_ready : upstream handshake; a payload moves on the cycle
//     both are high (valid may not depend on ready; ready never depends on valid).
//   in_*                  : retired-instruction payload from the LSU
//   commit_stall          : holds a buffered instruction uncommitted
//   wbu_valid             : one-cycle commit strobe qualifying wu_to_gu_bus
//   redirect_valid/pc     : trap redirect (ecall -> mtvec, mret -> mepc)
//   halt                  : sticky, set the edge after an ebreak commits
//   retire_cnt            : committed instruction count
//   dbg_state             : current FSM state
module ysyx_25020037_wbu
    import ysyx_25020037_wbu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RD_W  = 4,
    parameter int CNT_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lsu_valid,
    output logic                       wbu_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [RD_W-1:0]            in_rd,
    input  logic                       in_gpr_wen,
    input  logic [1:0]                 in_wb_sel,
    input  logic [XLEN-1:0]            in_alu_res,
    input  logic [XLEN-1:0]            in_load_data,
    input  logic [XLEN-1:0]            in_csr_rdata,
    input  logic [XLEN-1:0]            in_csr_wdata,
    input  logic [EU_TO_GU_BUS_WD-1:0] in_csr_wen,
    input  logic                       in_ecall,
    input  logic                       in_mret,
    input  logic                       in_ebreak,
    input  logic                       commit_stall,
    output logic                       wbu_valid,
    output logic [WU_TO_GU_BUS_WD-1:0] wu_to_gu_bus,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic                       halt,
    output logic [CNT_W-1:0]           retire_cnt,
    output logic [1:0]                 dbg_state
);

    wbu_state_e    r_state;
    wu_to_gu_bus_t r_bus;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_ebreak;
    logic             r_halt;
    logic [CNT_W-1:0] r_retire_cnt;

    logic          w_commit;
    logic          w_capture;
    logic          w_trap;
    logic          w_mret_en;
    logic [XLEN-1:0] w_gpr_wdata;
    logic          w_gpr_wen;
    wu_to_gu_bus_t w_next_bus;

    assign w_commit  = (r_state == ST_FULL) & ~commit_stall;
    // A committing ebreak must not let a younger instruction in behind it.
    assign wbu_ready = (r_state == ST_EMPTY) | (w_commit & ~r_ebreak);
    assign w_capture = lsu_valid & wbu_ready;

    assign w_trap    = in_ecall | in_mret;
    assign w_mret_en = in_mret & ~in_ecall;   // ecall has priority

    ysyx_25020037_wb_mux #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) u_wb_mux (
        .i_wb_sel    (in_wb_sel),
        .i_pc        (in_pc),
        .i_alu_res   (in_alu_res),
        .i_load_data (in_load_data),
        .i_csr_rdata (in_csr_rdata),
        .i_rd        (in_rd),
        .i_gpr_wen   (in_gpr_wen),
        .i_trap      (w_trap),
        .o_gpr_wdata (w_gpr_wdata),
        .o_gpr_wen   (w_gpr_wen)
    );

    always_comb begin
        w_next_bus               = '0;
        w_next_bus.rd            = in_rd;
        w_next_bus.ecall_en      = in_ecall;
        w_next_bus.mret_en       = w_mret_en;
        w_next_bus.csr_wen       = in_csr_wen;
        // On ecall the CSR write port carries the faulting pc into mepc.
        w_next_bus.csr_wcsr_data = in_ecall ? in_pc : in_csr_wdata;
        w_next_bus.gpr_wen       = w_gpr_wen;
        w_next_bus.gpr_wdata     = w_gpr_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_bus         <= '0;
            r_redirect_pc <= '0;
            r_ebreak      <= 1'b0;
            r_halt        <= 1'b0;
            r_retire_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_bus         <= w_next_bus;
                r_redirect_pc <= w_trap ? in_csr_rdata : '0;
                r_ebreak      <= in_ebreak;
            end
            if (w_commit) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_commit && r_ebreak) begin
                r_halt <= 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_capture) r_state <= ST_FULL;
                end
                ST_FULL: begin
                    if (w_commit) begin
                        if (r_ebreak)       r_state <= ST_HALTED;
                        else if (w_capture) r_state <= ST_FULL;
                        else                r_state <= ST_EMPTY;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_EMPTY;
            endcase
        end
    end

    assign wbu_valid      = w_commit;
    assign wu_to_gu_bus   = r_bus;
    assign redirect_valid = w_commit & (r_bus.ecall_en | r_bus.mret_en);
    assign redirect_pc    = r_redirect_pc;
    assign halt           = r_halt;
    assign retire_cnt     = r_retire_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
module tb_ysyx_25020037_wbu;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        wbu_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_rd;
  logic        in_gpr_wen;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_load_data;
  logic [31:0] in_csr_rdata;
  logic [31:0] in_csr_wdata;
  logic [2:0]  in_csr_wen;
  logic        in_ecall;
  logic        in_mret;
  logic        in_ebreak;
  logic        commit_stall;
  logic        wbu_valid;
  logic [73:0] wu_to_gu_bus;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [63:0] retire_cnt;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  // Bus fields, MSB first: rd, ecall_en, mret_en, csr_wen, csr data, gpr_wen, gpr_wdata
  logic [3:0]  b_rd;
  logic        b_ecall;
  logic        b_mret;
  logic [2:0]  b_csr_wen;
  logic [31:0] b_csr_data;
  logic        b_gpr_wen;
  logic [31:0] b_gpr_wdata;
  assign b_rd        = wu_to_gu_bus[73:70];
  assign b_ecall     = wu_to_gu_bus[69];
  assign b_mret      = wu_to_gu_bus[68];
  assign b_csr_wen   = wu_to_gu_bus[67:65];
  assign b_csr_data  = wu_to_gu_bus[64:33];
  assign b_gpr_wen   = wu_to_gu_bus[32];
  assign b_gpr_wdata = wu_to_gu_bus[31:0];

  ysyx_25020037_wbu dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_valid      (lsu_valid),
    .wbu_ready      (wbu_ready),
    .in_pc          (in_pc),
    .in_rd          (in_rd),
    .in_gpr_wen     (in_gpr_wen),
    .in_wb_sel      (in_wb_sel),
    .in_alu_res     (in_alu_res),
    .in_load_data   (in_load_data),
    .in_csr_rdata   (in_csr_rdata),
    .in_csr_wdata   (in_csr_wdata),
    .in_csr_wen     (in_csr_wen),
    .in_ecall       (in_ecall),
    .in_mret        (in_mret),
    .in_ebreak      (in_ebreak),
    .commit_stall   (commit_stall),
    .wbu_valid      (wbu_valid),
    .wu_to_gu_bus   (wu_to_gu_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .retire_cnt     (retire_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    lsu_valid    = 1'b0;
    in_pc        = '0;
    in_rd        = '0;
    in_gpr_wen   = 1'b0;
    in_wb_sel    = 2'd0;
    in_alu_res   = '0;
    in_load_data = '0;
    in_csr_rdata = '0;
    in_csr_wdata = '0;
    in_csr_wen   = '0;
    in_ecall     = 1'b0;
    in_mret      = 1'b0;
    in_ebreak    = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [3:0] rd, input logic gwen,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] ld,
                      input logic [31:0] csrr, input logic [31:0] csrw, input logic [2:0] cwen,
                      input logic ec, input logic mr, input logic eb);
    lsu_valid    = 1'b1;
    in_pc        = pc;
    in_rd        = rd;
    in_gpr_wen   = gwen;
    in_wb_sel    = sel;
    in_alu_res   = alu;
    in_load_data = ld;
    in_csr_rdata = csrr;
    in_csr_wdata = csrw;
    in_csr_wen   = cwen;
    in_ecall     = ec;
    in_mret      = mr;
    in_ebreak    = eb;
  endtask

  task automatic do_reset();
    idle();
    commit_stall = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    commit_stall = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", wbu_valid); end
    n_checks++; if (wbu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0h exp 1", wbu_ready); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %0h exp 0", halt); end
    n_checks++; if (retire_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %0h exp 0", retire_cnt); end
    n_checks++; if (wu_to_gu_bus !== 74'd0) begin n_fail++; $display("FAIL reset_bus got %0h exp 0", wu_to_gu_bus); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got %0h exp 0", redirect_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_addi();
    do_reset();
    next_cycle();
    send(32'h8000_0000, 4'd5, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (wbu_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %0h exp 1", wbu_ready); end
    n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL addi_early_valid got %0h exp 0", wbu_valid); end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0h exp 1", wbu_valid); end
    n_checks++; if (b_rd !== 4'd5) begin n_fail++; $display("FAIL addi_rd got %0h exp 5", b_rd); end
    n_checks++; if (b_gpr_wen !== 1'b1) begin n_fail++; $display("FAIL addi_gpr_wen got %0h exp 1", b_gpr_wen); end
    n_checks++; if (b_gpr_wdata !== 32'h1234) begin n_fail++; $display("FAIL addi_wdata got %0h exp 1234", b_gpr_wdata); end
    n_checks++; if (retire_cnt !== 64'd0) begin n_fail++; $display("FAIL addi_cnt_before got %0h exp 0", retire_cnt); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (retire_cnt !== 64'd1) begin n_fail++; $display("FAIL addi_cnt_after got %0h exp 1", retire_cnt); end
    n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL addi_one_pulse got %0h exp 0", wbu_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      next_cycle();
      if (i < 4) send(32'h8000_0000 + 32'(4 * i), 4'(i + 1), 1'b1, 2'd0, 32'h100 + 32'(i),
                      32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      if (i < 4) begin
        n_checks++; if (wbu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0h exp 1", i, wbu_ready); end
      end
      if (i > 0) begin
        n_checks++; if (wbu_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0h exp 1", i, wbu_valid); end
        n_checks++; if (b_rd !== 4'(i)) begin n_fail++; $display("FAIL b2b_rd[%0d] got %0h exp %0h", i, b_rd, i); end
        n_checks++; if (b_gpr_wdata !== 32'h100 + 32'(i - 1)) begin n_fail++; $display("FAIL b2b_wdata[%0d] got %0h exp %0h", i, b_gpr_wdata, 32'h100 + 32'(i - 1)); end
      end
    end
    next_cycle();
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0h exp 0", wbu_valid); end
    n_checks++; if (retire_cnt !== 64'd4) begin n_fail++; $display("FAIL b2b_cnt got %0h exp 4", retire_cnt); end
  endtask

  task automatic test_wb_sel();
    do_reset();
    next_cycle();
    send(32'h8000_0010, 4'd0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    send(32'h8000_0010, 4'd1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (b_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL jal_rd0_wen got %0h exp 0", b_gpr_wen); end
    next_cycle();
    send(32'hFFFF_FFFC, 4'd1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (b_gpr_wen !== 1'b1) begin n_fail++; $display("FAIL jal_rd1_wen got %0h exp 1", b_gpr_wen); end
    n_checks++; if (b_gpr_wdata !== 32'h8000_0014) begin n_fail++; $display("FAIL jal_rd1_wdata got %0h exp 80000014", b_gpr_wdata); end
    next_cycle();
    send(32'h0, 4'd2, 1'b1, 2'd1, 32'h1, 32'hA5A5_0F0F, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (b_gpr_wdata !== 32'h0) begin n_fail++; $display("FAIL jal_wrap_wdata got %0h exp 0", b_gpr_wdata); end
    next_cycle();
    send(32'h0, 4'd2, 1'b0, 2'd2, 32'h1, 32'h0, 32'h0000_0077, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (b_gpr_wdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL load_wdata got %0h exp a5a50f0f", b_gpr_wdata); end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (b_gpr_wdata !== 32'h77) begin n_fail++; $display("FAIL csrsel_wdata got %0h exp 77", b_gpr_wdata); end
    n_checks++; if (b_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL csrsel_wen got %0h exp 0", b_gpr_wen); end
  endtask

  task automatic test_trap();
    do_reset();
    next_cycle();
    send(32'h8000_0100, 4'd3, 1'b1, 2'd0, 32'h9, 32'h0, 32'h8000_1000, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (b_ecall !== 1'b1) begin n_fail++; $display("FAIL ecall_en got %0h exp 1", b_ecall); end
    n_checks++; if (b_mret !== 1'b0) begin n_fail++; $display("FAIL ecall_mret got %0h exp 0", b_mret); end
    n_checks++; if (b_csr_data !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_mepc got %0h exp 80000100", b_csr_data); end
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ecall_redirect got %0h exp 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL ecall_target got %0h exp 80001000", redirect_pc); end
    n_checks++; if (b_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL ecall_gpr_wen got %0h exp 0", b_gpr_wen); end
    next_cycle();
    send(32'h8000_0104, 4'd3, 1'b0, 2'd0, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ecall_redirect_1cyc got %0h exp 0", redirect_valid); end
    next_cycle();
    send(32'h8000_0200, 4'd4, 1'b1, 2'd0, 32'h0, 32'h0, 32'h8000_0300, 32'h1111_2222, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (b_mret !== 1'b0) begin n_fail++; $display("FAIL both_mret got %0h exp 0", b_mret); end
    n_checks++; if (b_ecall !== 1'b1) begin n_fail++; $display("FAIL both_ecall got %0h exp 1", b_ecall); end
    next_cycle();
    send(32'h8000_0400, 4'd7, 1'b1, 2'd2, 32'h0, 32'h0, 32'h55, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (b_mret !== 1'b1) begin n_fail++; $display("FAIL mret_en got %0h exp 1", b_mret); end
    n_checks++; if (redirect_pc !== 32'h8000_0300) begin n_fail++; $display("FAIL mret_target got %0h exp 80000300", redirect_pc); end
    n_checks++; if (b_gpr_wen !== 1'b0) begin n_fail++; $display("FAIL mret_gpr_wen got %0h exp 0", b_gpr_wen); end
    n_checks++; if (b_csr_data !== 32'h1111_2222) begin n_fail++; $display("FAIL mret_csr_data got %0h exp 11112222", b_csr_data); end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (b_csr_wen !== 3'b010) begin n_fail++; $display("FAIL csrw_wen got %0h exp 2", b_csr_wen); end
    n_checks++; if (b_csr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL csrw_data got %0h exp deadbeef", b_csr_data); end
    n_checks++; if (b_gpr_wen !== 1'b1 || b_gpr_wdata !== 32'h55) begin n_fail++; $display("FAIL csrw_gpr got %0h/%0h exp 1/55", b_gpr_wen, b_gpr_wdata); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL csrw_redirect got %0h exp 0", redirect_valid); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (retire_cnt !== 64'd4) begin n_fail++; $display("FAIL trap_cnt got %0h exp 4", retire_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle();
    send(32'h0, 4'd9, 1'b1, 2'd0, 32'hAAAA, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    send(32'h0, 4'd10, 1'b1, 2'd0, 32'hBBBB, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    commit_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d] got %0h exp 0", i, wbu_valid); end
      n_checks++; if (wbu_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %0h exp 0", i, wbu_ready); end
      n_checks++; if (b_rd !== 4'd9 || b_gpr_wdata !== 32'hAAAA) begin n_fail++; $display("FAIL stall_bus[%0d] got %0h/%0h exp 9/aaaa", i, b_rd, b_gpr_wdata); end
      if (i < 2) next_cycle();
    end
    next_cycle();
    commit_stall = 1'b0;
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b1 || b_gpr_wdata !== 32'hAAAA) begin n_fail++; $display("FAIL release_first got %0h/%0h exp 1/aaaa", wbu_valid, b_gpr_wdata); end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b1 || b_gpr_wdata !== 32'hBBBB) begin n_fail++; $display("FAIL release_second got %0h/%0h exp 1/bbbb", wbu_valid, b_gpr_wdata); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (retire_cnt !== 64'd2) begin n_fail++; $display("FAIL stall_cnt got %0h exp 2", retire_cnt); end
  endtask

  task automatic test_halt_and_async_reset();
    do_reset();
    next_cycle();
    send(32'h0, 4'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    send(32'h4, 4'd6, 1'b1, 2'd0, 32'h6666, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b1) begin n_fail++; $display("FAIL ebreak_commit got %0h exp 1", wbu_valid); end
    n_checks++; if (wbu_ready !== 1'b0) begin n_fail++; $display("FAIL ebreak_ready got %0h exp 0", wbu_ready); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL ebreak_halt_early got %0h exp 0", halt); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky[%0d] got %0h exp 1", i, halt); end
      n_checks++; if (wbu_valid !== 1'b0 || wbu_ready !== 1'b0) begin n_fail++; $display("FAIL halted_hs[%0d] got %0h/%0h exp 0/0", i, wbu_valid, wbu_ready); end
      n_checks++; if (retire_cnt !== 64'd1) begin n_fail++; $display("FAIL halted_cnt[%0d] got %0h exp 1", i, retire_cnt); end
    end
    // Asynchronous reset pulse landing between clock edges.
    #2 rst = 1'b1;
    #1;
    n_checks++; if (halt !== 1'b0 || retire_cnt !== 64'd0) begin n_fail++; $display("FAIL async_rst_halt got %0h/%0h exp 0/0", halt, retire_cnt); end
    #1 rst = 1'b0;
    idle();
    next_cycle();
    send(32'h8, 4'd8, 1'b1, 2'd0, 32'h8888, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++; if (wbu_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_commit got %0h exp 1", wbu_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (wbu_valid !== 1'b0) begin n_fail++; $display("FAIL mid_full_rst_valid got %0h exp 0", wbu_valid); end
    n_checks++; if (wu_to_gu_bus !== 74'd0 || retire_cnt !== 64'd0) begin n_fail++; $display("FAIL mid_full_rst_state got %0h/%0h exp 0/0", wu_to_gu_bus, retire_cnt); end
    n_checks++; if (wbu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_full_rst_ready got %0h exp 1", wbu_ready); end
    #1 rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_wb_sel();
    test_trap();
    test_stall();
    test_halt_and_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
- Write-back/commit stage of the NPC core; the producer end of the wu_to_gu_bus and wbu_valid interface consumed by the GPR/CSR register file.
- Accepts one retired instruction per handshake from the LSU and holds it in a one-entry stage register.
- Selects the write-back value, then issues exactly one commit pulse per instruction carrying the GPR write, CSR write and trap control.
- Also produces a trap redirect, a retired-instruction counter and the ebreak halt.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 4, register index width (16 GPRs).
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- lsu_valid  in  1  upstream payload valid
- wbu_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  pc of instruction
- in_rd  in  RD_W  destination register
- in_gpr_wen  in  1  instruction writes rd
- in_wb_sel  in  2  write-back source select
- in_alu_res  in  XLEN  ALU result
- in_load_data  in  XLEN  load data (already extended)
- in_csr_rdata  in  XLEN  CSR read value (mtvec on ecall, mepc on mret)
- in_csr_wdata  in  XLEN  CSR write value
- in_csr_wen  in  3  {mtvec_wen, mepc_wen, mstatus_wen}
- in_ecall  in  1  ecall
- in_mret  in  1  mret
- in_ebreak  in  1  ebreak
- commit_stall  in  1  external hold (difftest/debug)
- wbu_valid  out  1  commit strobe to register file
- wu_to_gu_bus  out  74  {rd[4], ecall_en, mret_en, csr_wen[3], csr_wcsr_data[32], gpr_wen, gpr_wdata[32]}, MSB first
- redirect_valid  out  1  trap redirect this cycle
- redirect_pc  out  XLEN  redirect target
- halt  out  1  ebreak retired; sticky
- retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous, active-high.
- On reset, all of the following clear immediately, including in the middle of an operation, and any in-flight instruction is dropped:
  - state to EMPTY
  - all payload registers to 0
  - wbu_valid, redirect_valid and halt to 0
  - retire_cnt to 0
- FSM states: EMPTY, FULL, HALTED.
- Commit condition: commit = (state==FULL) & ~commit_stall.
- wbu_ready = (state==EMPTY) | commit, where commit excludes a buffered ebreak. wbu_ready is 0 in HALTED.
- Capture: on lsu_valid & wbu_ready the stage registers the processed payload. wbu_valid rises in the following cycle, so latency is 1 cycle.
- Throughput: back-to-back capture and commit in the same cycle sustains 1 instruction per cycle.
- Transitions:
  - EMPTY to FULL on capture.
  - FULL stays FULL on commit plus capture, or on stall.
  - FULL to EMPTY on commit without capture.
  - FULL to HALTED on commit of an ebreak.
  - HALTED is held until reset.
- wb_sel encodings: 0 = alu_res, 1 = load_data, 2 = csr_rdata, 3 = pc+4 (modulo 2^XLEN). The mux is evaluated at capture, so gpr_wdata is registered.
- gpr_wen field = in_gpr_wen & (in_rd != 0); rd==0 never requests a write.
- ecall:
  - ecall_en = 1.
  - csr_wcsr_data = in_pc, so the register file stores mepc.
  - redirect target = in_csr_rdata (mtvec).
  - gpr_wen is forced to 0.
- mret: mret_en = 1, redirect target = in_csr_rdata (mepc), gpr_wen forced to 0.
- ecall and mret together: ecall wins and mret_en is cleared.
- CSR write instructions (no trap): csr_wen and in_csr_wdata are passed through unchanged. gpr_wen and gpr_wdata follow wb_sel 2 normally.
- redirect_valid = commit & (ecall_en | mret_en); redirect_pc is the registered target.
- wu_to_gu_bus holds the last captured payload. The register file qualifies every field with wbu_valid; wbu_valid = commit.
- retire_cnt increments by 1 on each commit and wraps at 2^CNT_W.
- halt sets on the clock edge following an ebreak commit and is sticky. wbu_valid is never asserted in HALTED.
- While commit_stall is held, the payload, bus and redirect target stay stable.

Decomposition:
- Shared config header:
  - WB_SEL_* encodings
  - WU_TO_GU_BUS_WD = 74
  - EU_TO_GU_BUS_WD = 3
  - state encodings
- One natural sub-module, ysyx_25020037_wb_mux: combinational 4:1 result select plus the rd0 and trap gating of gpr_wen. Sequencing stays in the top module.

Test Plan:
- addi x5 (rd=5, wb_sel=0, alu=0x1234), one handshake -> next cycle wbu_valid=1, bus rd=5, gpr_wen=1, gpr_wdata=0x1234; retire_cnt 0->1.
- 4 instructions on consecutive cycles with lsu_valid held -> wbu_ready stays 1, wbu_valid high 4 consecutive cycles, payloads in order, retire_cnt=4.
- jal rd=0 (wb_sel=3, pc=0x80000010) -> gpr_wen=0; with rd=1 instead -> gpr_wdata=0x80000014; pc=0xFFFFFFFC with rd=1 -> gpr_wdata=0x0.
- ecall pc=0x80000100, csr_rdata=0x80001000 -> ecall_en=1, csr_wcsr_data=0x80000100, redirect_valid=1 for 1 cycle, redirect_pc=0x80001000, gpr_wen=0; ecall+mret together -> mret_en=0.
- commit_stall high 3 cycles while FULL, lsu_valid=1 -> wbu_valid=0 and wbu_ready=0 throughout, bus stable; after release exactly one commit, then the next instruction commits.
- ebreak, then lsu_valid held -> ebreak commits once, halt=1 next cycle, wbu_ready=0 thereafter; async rst pulse mid-FULL -> wbu_valid=0 immediately, halt=0, retire_cnt=0.
